// File: rtl/rvx_core_bus_arbiter.sv
// rvx_core_bus_arbiter: merges the core ibus and dbus onto one shared memory port, one transaction at a time.
// Define RVX_BUS_ARBITER_ROUND_ROBIN_EN to alternate grants when both buses are waiting (default: dbus priority).
module rvx_core_bus_arbiter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] ibus_address,
    input  logic        ibus_rrequest,
    output logic [31:0] ibus_rdata,
    output logic        ibus_rresponse,
    input  logic [31:0] dbus_address,
    input  logic        dbus_rrequest,
    input  logic        dbus_wrequest,
    input  logic [31:0] dbus_wdata,
    input  logic [3:0]  dbus_wstrobe,
    output logic [31:0] dbus_rdata,
    output logic        dbus_rresponse,
    output logic        dbus_wresponse,
    output logic [31:0] mem_address,
    output logic        mem_rrequest,
    output logic        mem_wrequest,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrobe,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rresponse,
    input  logic        mem_wresponse
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    state_t      state_q, state_d;
    logic        i_pend_q, i_pend_d, d_pend_q, d_pend_d, d_write_q, d_write_d;
    logic [31:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d, d_wdata_q, d_wdata_d;
    logic [3:0]  d_wstrobe_q, d_wstrobe_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  wstrobe_q, wstrobe_d;
    logic        rreq_q, rreq_d, wreq_q, wreq_d;
    logic        i_clr, d_clr, i_acc, d_acc, go, pick_d, pick_i, prefer_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            i_pend_q    <= 1'b0;
            i_addr_q    <= '0;
            d_pend_q    <= 1'b0;
            d_write_q   <= 1'b0;
            d_addr_q    <= '0;
            d_wdata_q   <= '0;
            d_wstrobe_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrobe_q   <= '0;
            rreq_q      <= 1'b0;
            wreq_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_pend_q    <= i_pend_d;
            i_addr_q    <= i_addr_d;
            d_pend_q    <= d_pend_d;
            d_write_q   <= d_write_d;
            d_addr_q    <= d_addr_d;
            d_wdata_q   <= d_wdata_d;
            d_wstrobe_q <= d_wstrobe_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrobe_q   <= wstrobe_d;
            rreq_q      <= rreq_d;
            wreq_q      <= wreq_d;
        end
    end

    // Slots see this cycle's requests and completions, so arbitration happens in the same cycle.
    always_comb begin
        i_clr       = state_q == BUSY_I && mem_rresponse;
        d_clr       = state_q == BUSY_D && (d_write_q ? mem_wresponse : mem_rresponse);
        i_acc       = ibus_rrequest && (!i_pend_q || i_clr);
        d_acc       = (dbus_rrequest || dbus_wrequest) && (!d_pend_q || d_clr);
        i_pend_d    = (i_pend_q && !i_clr) || i_acc;
        d_pend_d    = (d_pend_q && !d_clr) || d_acc;
        i_addr_d    = i_acc ? ibus_address : i_addr_q;
        d_write_d   = d_acc ? dbus_wrequest : d_write_q;
        d_addr_d    = d_acc ? dbus_address : d_addr_q;
        d_wdata_d   = d_acc ? dbus_wdata : d_wdata_q;
        d_wstrobe_d = d_acc ? dbus_wstrobe : d_wstrobe_q;
        go          = state_q == IDLE || i_clr || d_clr;
        pick_d      = go && d_pend_d && (!i_pend_d || prefer_d);
        pick_i      = go && i_pend_d && !pick_d;
        state_d     = pick_d ? BUSY_D : pick_i ? BUSY_I : go ? IDLE : state_q;
    end

    always_comb begin
        rreq_d         = pick_i || (pick_d && !d_write_d);
        wreq_d         = pick_d && d_write_d;
        addr_d         = pick_d ? d_addr_d : pick_i ? i_addr_d : addr_q;
        wdata_d        = pick_d ? d_wdata_d : wdata_q;
        wstrobe_d      = pick_d ? d_wstrobe_d : wstrobe_q;
        ibus_rresponse = i_clr;
        ibus_rdata     = state_q == BUSY_I ? mem_rdata : '0;
        dbus_rresponse = state_q == BUSY_D && !d_write_q && mem_rresponse;
        dbus_wresponse = state_q == BUSY_D && d_write_q && mem_wresponse;
        dbus_rdata     = state_q == BUSY_D ? mem_rdata : '0;
    end

`ifdef RVX_BUS_ARBITER_ROUND_ROBIN_EN
    logic last_q;
    always_ff @(posedge clock) last_q <= !reset_n ? 1'b0 : pick_d ? 1'b1 : pick_i ? 1'b0 : last_q;
    assign prefer_d = !last_q;
`else
    assign prefer_d = 1'b1;
`endif

    assign mem_address  = addr_q;
    assign mem_rrequest = rreq_q;
    assign mem_wrequest = wreq_q;
    assign mem_wdata    = wdata_q;
    assign mem_wstrobe  = wstrobe_q;
endmodule

// File: tb/tb_rvx_core_bus_arbiter.sv
// tb_rvx_core_bus_arbiter: directed scenarios plus randomized traffic against a transaction-level model of the arbiter.
module tb_rvx_core_bus_arbiter;
    logic        clock = 1'b0, reset_n;
    logic [31:0] ibus_address, ibus_rdata, dbus_address, dbus_wdata, dbus_rdata;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic        ibus_rrequest, ibus_rresponse, dbus_rrequest, dbus_wrequest, dbus_rresponse, dbus_wresponse;
    logic [3:0]  dbus_wstrobe, mem_wstrobe;
    logic        mem_rrequest, mem_wrequest, mem_rresponse, mem_wresponse;
    int          checks = 0, failures = 0;
    // Model: pending slots, current owner (0 none, 1 ibus, 2 dbus), expected shared-port fields.
    bit          ip, dp, dw, last, rq, wq;
    int          own, lat, r;
    logic [31:0] ia, da, dd, ma, md;
    logic [3:0]  ds, ms;
    logic [31:0] exp_g [3];

    rvx_core_bus_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .ibus_address(ibus_address), .ibus_rrequest(ibus_rrequest), .ibus_rdata(ibus_rdata), .ibus_rresponse(ibus_rresponse),
        .dbus_address(dbus_address), .dbus_rrequest(dbus_rrequest), .dbus_wrequest(dbus_wrequest),
        .dbus_wdata(dbus_wdata), .dbus_wstrobe(dbus_wstrobe), .dbus_rdata(dbus_rdata),
        .dbus_rresponse(dbus_rresponse), .dbus_wresponse(dbus_wresponse),
        .mem_address(mem_address), .mem_rrequest(mem_rrequest), .mem_wrequest(mem_wrequest),
        .mem_wdata(mem_wdata), .mem_wstrobe(mem_wstrobe), .mem_rdata(mem_rdata),
        .mem_rresponse(mem_rresponse), .mem_wresponse(mem_wresponse)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        @(negedge clock);
        chk("ibus_rresponse", {31'b0, ibus_rresponse}, {31'b0, own == 1 && mem_rresponse});
        chk("ibus_rdata", ibus_rdata, own == 1 ? mem_rdata : 32'h0);
        chk("dbus_rresponse", {31'b0, dbus_rresponse}, {31'b0, own == 2 && !dw && mem_rresponse});
        chk("dbus_wresponse", {31'b0, dbus_wresponse}, {31'b0, own == 2 && dw && mem_wresponse});
        chk("dbus_rdata", dbus_rdata, own == 2 ? mem_rdata : 32'h0);
        chk("mem_rrequest", {31'b0, mem_rrequest}, {31'b0, rq});
        chk("mem_wrequest", {31'b0, mem_wrequest}, {31'b0, wq});
        chk("mem_address", mem_address, ma);
        if (own == 2 && dw) begin
            chk("mem_wdata", mem_wdata, md);
            chk("mem_wstrobe", {28'b0, mem_wstrobe}, {28'b0, ms});
        end
    endtask

    task automatic advance();
        bit pick_d;
        @(posedge clock);
        if ((own == 1 && mem_rresponse) || (own == 2 && (dw ? mem_wresponse : mem_rresponse))) begin
            if (own == 1) ip = 0; else dp = 0;
            own = 0;
        end
        rq = 0;
        wq = 0;
        if (ibus_rrequest && !ip) begin ip = 1; ia = ibus_address; end
        if ((dbus_rrequest || dbus_wrequest) && !dp) begin
            dp = 1; dw = dbus_wrequest; da = dbus_address; dd = dbus_wdata; ds = dbus_wstrobe;
        end
        if (own == 0 && (ip || dp)) begin
`ifdef RVX_BUS_ARBITER_ROUND_ROBIN_EN
            pick_d = dp && (!ip || !last);
`else
            pick_d = dp;
`endif
            last = pick_d;
            own = pick_d ? 2 : 1;
            ma = pick_d ? da : ia;
            rq = !pick_d || !dw;
            wq = pick_d && dw;
            if (pick_d) begin md = dd; ms = ds; end
        end
        if (!reset_n) begin
            ip = 0; dp = 0; dw = 0; last = 0; rq = 0; wq = 0; own = 0;
            ia = 0; da = 0; dd = 0; ds = 0; ma = 0; md = 0; ms = 0;
        end
        #1;
        ibus_rrequest = 0; dbus_rrequest = 0; dbus_wrequest = 0; mem_rresponse = 0; mem_wresponse = 0;
    endtask

    task automatic respond();
        if (own == 2 && dw) mem_wresponse = 1; else mem_rresponse = 1;
        mem_rdata = $urandom;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && (own != 0 || ip || dp); n++) begin
            if (own != 0 && !(rq || wq)) respond();
            sample();
            advance();
        end
    endtask

    initial begin
        reset_n = 0;
        ibus_address = 0; ibus_rrequest = 0; dbus_address = 0; dbus_rrequest = 0; dbus_wrequest = 0;
        dbus_wdata = 0; dbus_wstrobe = 0; mem_rdata = 32'h5555_AAAA; mem_rresponse = 0; mem_wresponse = 0;
        advance();
        advance();
        reset_n = 1;
        sample();
        chk("reset_mem_address", mem_address, 32'h0);
        chk("reset_mem_rrequest", {31'b0, mem_rrequest}, 32'h0);
        advance();

        // Instruction fetch
        ibus_rrequest = 1; ibus_address = 32'h100;
        sample(); advance();
        sample();
        chk("fetch_rreq", {31'b0, mem_rrequest}, 32'h1);
        chk("fetch_addr", mem_address, 32'h100);
        advance();
        sample(); advance();
        mem_rresponse = 1; mem_rdata = 32'hDEADBEEF;
        sample();
        chk("fetch_iresp", {31'b0, ibus_rresponse}, 32'h1);
        chk("fetch_idata", ibus_rdata, 32'hDEADBEEF);
        chk("fetch_dresp", {31'b0, dbus_rresponse}, 32'h0);
        advance();

        // Data write
        dbus_wrequest = 1; dbus_address = 32'h2004; dbus_wdata = 32'h12345678; dbus_wstrobe = 4'hF;
        sample(); advance();
        sample();
        chk("write_wreq", {31'b0, mem_wrequest}, 32'h1);
        chk("write_addr", mem_address, 32'h2004);
        chk("write_wdata", mem_wdata, 32'h12345678);
        chk("write_strb", {28'b0, mem_wstrobe}, 32'hF);
        advance();
        sample();
        chk("write_hold", mem_wdata, 32'h12345678);
        advance();
        mem_wresponse = 1;
        sample();
        chk("write_wresp", {31'b0, dbus_wresponse}, 32'h1);
        advance();

        // Simultaneous requests: dbus first
        ibus_rrequest = 1; ibus_address = 32'h10; dbus_rrequest = 1; dbus_address = 32'h20;
        sample(); advance();
        sample();
        chk("simul_first", mem_address, 32'h20);
        advance();
        mem_rresponse = 1; mem_rdata = 32'hA5A5_0001;
        sample();
        chk("simul_dresp", {31'b0, dbus_rresponse}, 32'h1);
        chk("simul_ddata", dbus_rdata, 32'hA5A5_0001);
        chk("simul_iresp0", {31'b0, ibus_rresponse}, 32'h0);
        advance();
        sample();
        chk("simul_second_rreq", {31'b0, mem_rrequest}, 32'h1);
        chk("simul_second", mem_address, 32'h10);
        advance();
        mem_rresponse = 1; mem_rdata = 32'hA5A5_0002;
        sample();
        chk("simul_iresp", {31'b0, ibus_rresponse}, 32'h1);
        chk("simul_idata", ibus_rdata, 32'hA5A5_0002);
        advance();

        // Starvation: dbus re-requests in every response cycle
`ifdef RVX_BUS_ARBITER_ROUND_ROBIN_EN
        exp_g[0] = 32'h40; exp_g[1] = 32'h30; exp_g[2] = 32'h40;
`else
        exp_g[0] = 32'h40; exp_g[1] = 32'h40; exp_g[2] = 32'h40;
`endif
        ibus_rrequest = 1; ibus_address = 32'h30; dbus_rrequest = 1; dbus_address = 32'h40;
        sample(); advance();
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("starve_rreq", {31'b0, mem_rrequest}, 32'h1);
            chk("starve_grant", mem_address, exp_g[k]);
            advance();
            mem_rresponse = 1; mem_rdata = 32'(k); dbus_rrequest = 1; dbus_address = 32'h40;
            sample(); advance();
        end
        drain();

        // Reset mid-transaction
        dbus_rrequest = 1; dbus_address = 32'h50;
        sample(); advance();
        sample(); advance();
        reset_n = 0;
        sample(); advance();
        reset_n = 1;
        sample();
        chk("rst_addr", mem_address, 32'h0);
        chk("rst_rreq", {31'b0, mem_rrequest}, 32'h0);
        advance();
        mem_rresponse = 1; mem_rdata = 32'h0BAD_0BAD;
        sample();
        chk("rst_late_dresp", {31'b0, dbus_rresponse}, 32'h0);
        chk("rst_late_ddata", dbus_rdata, 32'h0);
        advance();
        sample();
        chk("rst_still_idle", {31'b0, mem_rrequest}, 32'h0);
        advance();

        // Spurious responses while idle
        mem_rresponse = 1; mem_wresponse = 1; mem_rdata = 32'hFEED_F00D;
        sample();
        chk("spur_iresp", {31'b0, ibus_rresponse}, 32'h0);
        chk("spur_dresp", {31'b0, dbus_rresponse}, 32'h0);
        chk("spur_dwresp", {31'b0, dbus_wresponse}, 32'h0);
        advance();
        sample();
        chk("spur_no_req", {30'b0, mem_rrequest, mem_wrequest}, 32'h0);
        advance();

        // Randomized traffic with spurious/wrong-kind responses and occasional resets
        for (int c = 0; c < 3000; c++) begin
            ibus_rrequest = ($urandom % 4) == 0;
            ibus_address = $urandom;
            r = int'($urandom % 8);
            dbus_rrequest = r == 0 || r == 2;
            dbus_wrequest = r == 1 || r == 2;
            dbus_address = $urandom; dbus_wdata = $urandom; dbus_wstrobe = 4'($urandom);
            mem_rdata = $urandom;
            if (rq || wq) lat = int'($urandom_range(0, 2));
            else if (own != 0 && lat == 0) respond();
            else if (own != 0) begin
                lat--;
                if ($urandom % 8 == 0) begin
                    if (own == 2 && !dw) mem_wresponse = 1;
                    else if (own == 2) mem_rresponse = 1;
                    else mem_wresponse = 1;
                end
            end else if ($urandom % 8 == 0) begin
                mem_rresponse = 1'($urandom); mem_wresponse = 1'($urandom);
            end
            reset_n = ($urandom % 150) != 0;
            sample();
            advance();
            reset_n = 1;
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
